// File: rtl/fetch_front_ctrl.sv
// Fetch front end: PC, imem handshake, one-entry fetch buffer, IF/ID register.
// Responds to PCWrite/IFID_Write/HazZero stalls and taken-branch redirects.
module fetch_front_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IFID_Write,
  input  logic        HazZero,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        IDEX_Bubble,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic [31:0] pc4_d;
  logic        valid_d;
  logic [31:0] fbuf, fbuf_d;
  logic [31:0] drain_addr, drain_addr_d;
  logic [15:0] stall_d;

  logic        advance;
  logic        redirect;
  logic        ack;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign imem_req  = (state == FETCH) || (state == DRAIN);
  // DRAIN keeps the old address on the bus until the orphaned fetch returns
  assign imem_addr = (state == DRAIN) ? drain_addr : PC;

  assign advance  = PCWrite & IFID_Write;
  assign redirect = BranchTaken & PCWrite & (state != DRAIN);
  assign ack      = imem_ack & imem_req;
  assign pc_plus4 = PC + 32'd4;
  assign target   = BranchTarget & ~32'h3;

  always_comb begin
    state_d      = state;
    pc_d         = PC;
    instr_d      = IFID_Instr;
    pc4_d        = IFID_PCPlus4;
    valid_d      = IFID_Valid;
    fbuf_d       = fbuf;
    drain_addr_d = drain_addr;

    unique case (state)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (ack && advance) begin
          instr_d = imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else if (ack) begin
          fbuf_d  = imem_rdata;
          state_d = HOLD;
        end else if (advance) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (advance) begin
          instr_d = fbuf;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          fbuf_d  = NOP_INSTR;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (advance) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
        if (ack) begin
          state_d = FETCH;
        end
      end
    endcase

    // Redirect overrides whatever the fetch produced this cycle
    if (redirect) begin
      pc_d    = target;
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      fbuf_d  = NOP_INSTR;
      if (state == FETCH && !ack) begin
        state_d      = DRAIN;
        drain_addr_d = PC;
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_comb begin
    stall_d = StallCount;
    if (state != IDLE && !PCWrite && StallCount != 16'hFFFF) begin
      stall_d = StallCount + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      PC           <= RESET_PC;
      IFID_Instr   <= NOP_INSTR;
      IFID_PCPlus4 <= 32'd0;
      IFID_Valid   <= 1'b0;
      IDEX_Bubble  <= 1'b0;
      StallCount   <= 16'd0;
      fbuf         <= NOP_INSTR;
      drain_addr   <= RESET_PC;
    end else begin
      state        <= state_d;
      PC           <= pc_d;
      IFID_Instr   <= instr_d;
      IFID_PCPlus4 <= pc4_d;
      IFID_Valid   <= valid_d;
      IDEX_Bubble  <= HazZero;
      StallCount   <= stall_d;
      fbuf         <= fbuf_d;
      drain_addr   <= drain_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_front_ctrl.sv
// Bench for fetch_front_ctrl: hand-derived per-cycle vectors checked
// through an expected-result queue, plus long-stall and async-reset cases.
module tb_fetch_front_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite = 1'b0;
  logic        IFID_Write = 1'b0;
  logic        HazZero = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] PC;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        IDEX_Bubble;
  logic [15:0] StallCount;

  fetch_front_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .PCWrite(PCWrite),
    .IFID_Write(IFID_Write),
    .HazZero(HazZero),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .PC(PC),
    .IFID_Instr(IFID_Instr),
    .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid),
    .IDEX_Bubble(IDEX_Bubble),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcw, ifw, haz, br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr, e_pc, e_instr, e_pc4;
    logic        e_valid, e_bub;
    logic [15:0] e_sc;
  } vec_t;

  typedef struct {
    logic        req;
    logic [31:0] addr, pc, instr, pc4;
    logic        valid, bub;
    logic [15:0] sc;
  } exp_t;

  vec_t vt[23];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic pcw, ifw, haz, br, input logic [31:0] tgt,
    input logic ack, input logic [31:0] rdata,
    input logic e_req, input logic [31:0] e_addr, e_pc, e_instr, e_pc4,
    input logic e_valid, e_bub, input logic [15:0] e_sc);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.haz = haz; v.br = br; v.tgt = tgt;
    v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc;
    v.e_instr = e_instr; v.e_pc4 = e_pc4;
    v.e_valid = e_valid; v.e_bub = e_bub; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (imem_req !== e.req || imem_addr !== e.addr || PC !== e.pc ||
        IFID_Instr !== e.instr || IFID_PCPlus4 !== e.pc4 ||
        IFID_Valid !== e.valid || IDEX_Bubble !== e.bub ||
        StallCount !== e.sc) begin
      n_err++;
      $display("FAIL %s: got req=%b addr=%h pc=%h instr=%h pc4=%h v=%b bub=%b sc=%h; want req=%b addr=%h pc=%h instr=%h pc4=%h v=%b bub=%b sc=%h",
        name, imem_req, imem_addr, PC, IFID_Instr, IFID_PCPlus4,
        IFID_Valid, IDEX_Bubble, StallCount, e.req, e.addr, e.pc,
        e.instr, e.pc4, e.valid, e.bub, e.sc);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    PCWrite = v.pcw; IFID_Write = v.ifw; HazZero = v.haz;
    BranchTaken = v.br; BranchTarget = v.tgt;
    imem_ack = v.ack; imem_rdata = v.rdata;
    e.req = v.e_req; e.addr = v.e_addr; e.pc = v.e_pc;
    e.instr = v.e_instr; e.pc4 = v.e_pc4; e.valid = v.e_valid;
    e.bub = v.e_bub; e.sc = v.e_sc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d", idx), e);
  endtask

  function automatic exp_t rst_exp();
    exp_t e;
    e.req = 0; e.addr = 0; e.pc = 0; e.instr = 0; e.pc4 = 0;
    e.valid = 0; e.bub = 0; e.sc = 0;
    return e;
  endfunction

  initial begin
    exp_t e;
    //          pcw ifw haz br tgt           ack rdata         req addr          pc            instr         pc4           v  b  sc
    vt[0]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 16'd0);
    vt[1]  = mk(1, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h4,        32'h4,        32'h0,        32'h4,        1, 0, 16'd0);
    vt[2]  = mk(1, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h8,        32'h8,        32'h4,        32'h8,        1, 0, 16'd0);
    vt[3]  = mk(1, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'hC,        32'hC,        32'h8,        32'hC,        1, 0, 16'd0);
    vt[4]  = mk(0, 0, 0, 0, 32'h0,        1, 32'h8C220004, 0, 32'hC,        32'hC,        32'h8,        32'hC,        1, 0, 16'd1);
    vt[5]  = mk(1, 1, 0, 0, 32'h0,        1, 32'hDEAD0000, 1, 32'h10,       32'h10,       32'h8C220004, 32'h10,       1, 0, 16'd1);
    vt[6]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       32'h10,       32'h0,        32'h10,       0, 0, 16'd1);
    vt[7]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       32'h10,       32'h0,        32'h10,       0, 0, 16'd1);
    vt[8]  = mk(1, 1, 0, 0, 32'h0,        1, 32'h10,       1, 32'h14,       32'h14,       32'h10,       32'h14,       1, 0, 16'd1);
    vt[9]  = mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h14,       32'h14,       32'h0,        32'h14,       0, 1, 16'd1);
    vt[10] = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       32'h14,       32'h0,        32'h14,       0, 0, 16'd1);
    vt[11] = mk(0, 1, 0, 1, 32'h200,      0, 32'h0,        1, 32'h14,       32'h14,       32'h0,        32'h14,       0, 0, 16'd2);
    vt[12] = mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       32'h14,       32'h0,        32'h14,       0, 0, 16'd2);
    vt[13] = mk(1, 1, 0, 1, 32'h103,      0, 32'h0,        1, 32'h14,       32'h100,      32'h0,        32'h0,        0, 0, 16'd2);
    vt[14] = mk(1, 1, 0, 1, 32'h300,      0, 32'h0,        1, 32'h14,       32'h100,      32'h0,        32'h0,        0, 0, 16'd2);
    vt[15] = mk(1, 1, 0, 0, 32'h0,        1, 32'hBAD0BAD0, 1, 32'h100,      32'h100,      32'h0,        32'h0,        0, 0, 16'd2);
    vt[16] = mk(1, 1, 0, 0, 32'h0,        1, 32'h13,       1, 32'h104,      32'h104,      32'h13,       32'h104,      1, 0, 16'd2);
    vt[17] = mk(1, 1, 0, 1, 32'h40,       1, 32'h55,       1, 32'h40,       32'h40,       32'h0,        32'h0,        0, 0, 16'd2);
    vt[18] = mk(0, 0, 0, 0, 32'h0,        1, 32'h77,       0, 32'h40,       32'h40,       32'h0,        32'h0,        0, 0, 16'd3);
    vt[19] = mk(1, 0, 0, 1, 32'h80,       0, 32'h0,        1, 32'h80,       32'h80,       32'h0,        32'h0,        0, 0, 16'd3);
    vt[20] = mk(1, 1, 0, 0, 32'h0,        1, 32'h99,       1, 32'h84,       32'h84,       32'h99,       32'h84,       1, 0, 16'd3);
    vt[21] = mk(1, 1, 0, 1, 32'hFFFFFFFF, 1, 32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 0, 16'd3);
    vt[22] = mk(1, 1, 0, 0, 32'h0,        1, 32'hABCD,     1, 32'h0,        32'h0,        32'hABCD,     32'h0,        1, 0, 16'd3);

    #3;
    check("reset", rst_exp());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) step(vt[i], i);

    @(negedge clk);
    PCWrite = 0; IFID_Write = 0; BranchTaken = 0; imem_ack = 0;
    repeat (70000) @(posedge clk);
    #1;
    e.req = 1; e.addr = 0; e.pc = 0; e.instr = 32'hABCD; e.pc4 = 0;
    e.valid = 1; e.bub = 0; e.sc = 16'hFFFF;
    check("stall_sat", e);
    repeat (5) @(posedge clk);
    #1;
    check("stall_nowrap", e);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", rst_exp());
    @(negedge clk);
    imem_ack = 1; imem_rdata = 32'h1234;
    PCWrite = 1; IFID_Write = 1;
    @(posedge clk);
    #1;
    check("reset_ack_ignored", rst_exp());
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 0;
    step(mk(1, 1, 0, 0, 32'h0, 0, 32'h0,
            1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 16'd0), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
